// File: rtl/cache_mesi_fsm.sv
// cache_mesi_fsm: per-line MESI coherence controller with registered bus, L1-message and snoop-result outputs
module cache_mesi_fsm (
    input  logic       clk,
    input  logic       rstb,
    input  logic [3:0] nmsg_in,
    input  logic       C_in,
    output logic [2:0] bus_func_out,
    output logic [2:0] l2tol1msg_out,
    output logic       BusRd_out,
    output logic       BusRdX_out,
    output logic       BusUpgr_out_new,
    output logic       Flush,
    output logic [1:0] C_out,
    output logic [1:0] mesi_states_out
);
    typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} state_t;
    localparam logic [3:0] RD_D = 4'd0, WR_D = 4'd1, RD_I = 4'd2, SNP_INV = 4'd3, SNP_RD = 4'd4, SNP_RWM = 4'd6;
    localparam logic [2:0] NONE = 3'd0, READ = 3'd1, WRITE = 3'd2, INVALIDATE = 3'd3, RWIM = 3'd4;
    localparam logic [2:0] NOMSG = 3'd0, GETLINE = 3'd1, SENDLINE = 3'd2, INVALIDATELINE = 3'd3, EVICTLINE = 3'd4;
    localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
    state_t state, nxt;
    logic [2:0] bus, msg;
    logic [1:0] c;
    logic rd, wr;
    assign rd = (nmsg_in == RD_D) || (nmsg_in == RD_I);
    assign wr = nmsg_in == WR_D;
    always_comb begin
        nxt = state;
        bus = NONE;
        msg = rd ? SENDLINE : NOMSG;
        c = NOHIT;
        case (state)
            ST_I: begin
                if (rd) begin
                    nxt = C_in ? ST_S : ST_E;
                    bus = READ;
                end else if (wr) begin
                    nxt = ST_M;
                    bus = RWIM;
                    msg = EVICTLINE;
                end
            end
            ST_S: begin
                if (wr) begin
                    nxt = ST_M;
                    bus = INVALIDATE;
                end else if (nmsg_in == SNP_RD) c = HIT;
                else if (nmsg_in == SNP_INV || nmsg_in == SNP_RWM) begin
                    nxt = ST_I;
                    msg = INVALIDATELINE;
                end
            end
            ST_E: begin
                if (wr) nxt = ST_M;
                else if (nmsg_in == SNP_RD) begin
                    nxt = ST_S;
                    c = HIT;
                end else if (nmsg_in == SNP_RWM) begin
                    nxt = ST_I;
                    msg = INVALIDATELINE;
                end
            end
            default: begin
                // a modified line is written back on any read snoop
                if (nmsg_in == SNP_RD || nmsg_in == SNP_RWM) begin
                    nxt = nmsg_in == SNP_RD ? ST_S : ST_I;
                    bus = WRITE;
                    msg = nmsg_in == SNP_RD ? GETLINE : EVICTLINE;
                    c = HITM;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= ST_I;
            bus_func_out <= NONE;
            l2tol1msg_out <= NOMSG;
            C_out <= NOHIT;
        end else begin
            state <= nxt;
            bus_func_out <= bus;
            l2tol1msg_out <= msg;
            C_out <= c;
        end
    end
    assign mesi_states_out = state;
    assign BusRd_out = bus_func_out == READ;
    assign BusRdX_out = bus_func_out == RWIM;
    assign BusUpgr_out_new = bus_func_out == INVALIDATE;
    assign Flush = bus_func_out == WRITE;
endmodule

// File: tb/tb_cache_mesi_fsm.sv
// tb_cache_mesi_fsm: random and directed checks of cache_mesi_fsm against a command-oriented MESI model
module tb_cache_mesi_fsm;
    logic clk = 1'b0;
    logic rstb = 1'b1;
    logic [3:0] nmsg_in = 4'd15;
    logic C_in = 1'b0;
    logic [2:0] bus_func_out, l2tol1msg_out;
    logic BusRd_out, BusRdX_out, BusUpgr_out_new, Flush;
    logic [1:0] C_out, mesi_states_out;
    int compared = 0, mismatched = 0;
    int ms = 0, mbus = 0, mmsg = 0, mc = 0;

    cache_mesi_fsm dut (
        .clk(clk), .rstb(rstb), .nmsg_in(nmsg_in), .C_in(C_in),
        .bus_func_out(bus_func_out), .l2tol1msg_out(l2tol1msg_out),
        .BusRd_out(BusRd_out), .BusRdX_out(BusRdX_out), .BusUpgr_out_new(BusUpgr_out_new),
        .Flush(Flush), .C_out(C_out), .mesi_states_out(mesi_states_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    // states I=0 S=1 E=2 M=3; rules grouped by the incoming command
    task automatic model(input logic rst, input int cmd, input logic c);
        int ns, nb, nm, nc;
        ns = ms; nb = 0; nm = 0; nc = 0;
        if (rst) ns = 0;
        else if (cmd == 0 || cmd == 2) begin
            nm = 2;
            if (ms == 0) begin ns = c ? 1 : 2; nb = 1; end
        end else if (cmd == 1) begin
            ns = 3;
            nb = (ms == 0) ? 4 : (ms == 1) ? 3 : 0;
            nm = (ms == 0) ? 4 : 0;
        end else if (cmd == 4) begin
            if (ms == 1 || ms == 2) begin ns = 1; nc = 1; end
            if (ms == 3) begin ns = 1; nb = 2; nm = 1; nc = 2; end
        end else if (cmd == 6) begin
            if (ms == 1 || ms == 2) begin ns = 0; nm = 3; end
            if (ms == 3) begin ns = 0; nb = 2; nm = 4; nc = 2; end
        end else if (cmd == 3) begin
            if (ms == 1) begin ns = 0; nm = 3; end
        end
        ms = ns; mbus = nb; mmsg = nm; mc = nc;
    endtask

    task automatic step(input logic rst, input int cmd, input logic c);
        @(negedge clk);
        rstb = rst;
        nmsg_in = cmd[3:0];
        C_in = c;
        model(rst, cmd, c);
        @(posedge clk);
        #1;
        chk("state", {6'd0, mesi_states_out}, ms[7:0]);
        chk("bus", {5'd0, bus_func_out}, mbus[7:0]);
        chk("l2tol1", {5'd0, l2tol1msg_out}, mmsg[7:0]);
        chk("c_out", {6'd0, C_out}, mc[7:0]);
        chk("busrd", {7'd0, BusRd_out}, {7'd0, mbus == 1});
        chk("busrdx", {7'd0, BusRdX_out}, {7'd0, mbus == 4});
        chk("busupgr", {7'd0, BusUpgr_out_new}, {7'd0, mbus == 3});
        chk("flush", {7'd0, Flush}, {7'd0, mbus == 2});
    endtask

    initial begin
        int r, cmd;
        step(1, 15, 0);
        chk("lit_reset_state", {6'd0, mesi_states_out}, 8'd0);
        chk("lit_reset_msg", {5'd0, l2tol1msg_out}, 8'd0);
        step(0, 1, 0);
        chk("lit_iw_state", {6'd0, mesi_states_out}, 8'd3);
        chk("lit_iw_bus", {5'd0, bus_func_out}, 8'd4);
        chk("lit_iw_msg", {5'd0, l2tol1msg_out}, 8'd4);
        chk("lit_iw_busrdx", {7'd0, BusRdX_out}, 8'd1);
        step(0, 6, 0);
        chk("lit_mrwm_state", {6'd0, mesi_states_out}, 8'd0);
        chk("lit_mrwm_flush", {7'd0, Flush}, 8'd1);
        chk("lit_mrwm_cout", {6'd0, C_out}, 8'd2);
        step(1, 15, 0);
        step(0, 0, 1);
        chk("lit_ir_shared", {6'd0, mesi_states_out}, 8'd1);
        chk("lit_ir_bus", {5'd0, bus_func_out}, 8'd1);
        step(0, 1, 0);
        chk("lit_sw_bus", {5'd0, bus_func_out}, 8'd3);
        chk("lit_sw_upgr", {7'd0, BusUpgr_out_new}, 8'd1);
        step(0, 4, 0);
        chk("lit_msr_bus", {5'd0, bus_func_out}, 8'd2);
        step(0, 4, 0);
        chk("lit_ssr_cout", {6'd0, C_out}, 8'd1);
        chk("lit_ssr_bus", {5'd0, bus_func_out}, 8'd0);
        step(0, 3, 0);
        chk("lit_sinv_state", {6'd0, mesi_states_out}, 8'd0);
        step(0, 0, 0);
        chk("lit_ir_excl", {6'd0, mesi_states_out}, 8'd2);
        step(0, 0, 0);
        chk("lit_er_msg", {5'd0, l2tol1msg_out}, 8'd2);
        step(0, 1, 0);
        chk("lit_ew_state", {6'd0, mesi_states_out}, 8'd3);
        chk("lit_ew_bus", {5'd0, bus_func_out}, 8'd0);
        step(0, 1, 0);
        step(1, 1, 0);
        chk("lit_rst_mid_state", {6'd0, mesi_states_out}, 8'd0);
        chk("lit_rst_mid_bus", {5'd0, bus_func_out}, 8'd0);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            cmd = r < 7 ? r : (r == 7 ? 15 : $urandom_range(7, 14));
            step($urandom_range(0, 39) == 0, cmd, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
